// File: rtl/axil_apb_pkg.sv
// Shared types and constants for the AXI-Lite to APB bridge.
// Holds the FSM state encoding, AXI response codes and the completer-select width helper.
package axil_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WRESP  = 3'd3,
        ST_RRESP  = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Never narrower than one bit so the index stays a legal vector; the
    // bridge forces it to zero when there is a single completer.
    function automatic int slv_sel_w(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

endpackage

// File: rtl/apb_slv_mux.sv
// Completer decode: drives the one-hot psel from the index and returns the
// addressed completer's prdata/pready/pslverr (zeros for an out-of-range index).
module apb_slv_mux
    import axil_apb_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = slv_sel_w(NUM_SLV)
) (
    input  logic [IDX_W-1:0]          idx,
    input  logic                      active,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    output logic [NUM_SLV-1:0]        psel,
    output logic [DATA_W-1:0]         rdata_sel,
    output logic                      ready_sel,
    output logic                      err_sel
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        psel      = '0;
        rdata_sel = '0;
        ready_sel = 1'b0;
        err_sel   = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (int'(idx) == i) begin
                psel[i]   = active;
                rdata_sel = prdata[i*DATA_W +: DATA_W];
                ready_sel = pready[i];
                err_sel   = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/axil_apb_bridge_ms.sv
// AXI-Lite to multi-completer APB bridge, one transaction in flight, fair write/read arbitration.
// Define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYC cycles (SLVERR on expiry).
module axil_apb_bridge_ms
    import axil_apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      aclk,
    input  logic                      areset,
    // AXI-Lite write
    input  logic [ADDR_W-1:0]         awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    // AXI-Lite read
    input  logic [ADDR_W-1:0]         araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_W-1:0]         rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    // APB
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    // debug
    output logic [2:0]                state
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = slv_sel_w(NUM_SLV);

    state_t              cur, nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                pwrite_q;
    logic [IDX_W-1:0]    idx_q;
    logic [1:0]          resp_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                last_wr;

    logic                wr_req, rd_req;
    logic                grant_wr, grant_rd;
    logic [ADDR_W-1:0]   acc_addr;
    logic [IDX_W-1:0]    acc_idx;
    logic                acc_decerr;
    logic                xfer_act;
    logic [DATA_W-1:0]   sel_rdata;
    logic                sel_ready, sel_err;
    logic                timeout;

    // Fair arbitration: on a tie, serve whichever type was not served last.
    // Grants are masked during reset so no ready pulses while areset is high.
    assign wr_req     = awvalid && wvalid;
    assign rd_req     = arvalid;
    assign grant_wr   = (cur == ST_IDLE) && !areset && wr_req && (!rd_req || !last_wr);
    assign grant_rd   = (cur == ST_IDLE) && !areset && rd_req && (!wr_req || last_wr);
    assign acc_addr   = grant_wr ? awaddr : araddr;
    assign acc_idx    = (NUM_SLV > 1) ? acc_addr[SEL_LSB +: IDX_W] : '0;
    assign acc_decerr = int'(acc_idx) >= NUM_SLV;

    assign xfer_act = (cur == ST_SETUP) || (cur == ST_ACCESS);

    apb_slv_mux #(
        .NUM_SLV (NUM_SLV),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) u_mux (
        .idx       (idx_q),
        .active    (xfer_act),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .psel      (psel),
        .rdata_sel (sel_rdata),
        .ready_sel (sel_ready),
        .err_sel   (sel_err)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge aclk) begin
        if (areset || cur != ST_ACCESS) tmo_cnt <= '0;
        else                            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // tmo_cnt holds the number of ACCESS cycles already spent; fire on the last allowed one.
    assign timeout = (cur == ST_ACCESS) && !sel_ready && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT_CYC == 0);
    assign timeout    = 1'b0;
`endif

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge aclk) begin
        if (areset) cur <= ST_IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt     = cur;
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        case (cur)
            ST_IDLE: begin
                if (grant_wr || grant_rd) begin
                    awready = grant_wr;
                    wready  = grant_wr;
                    arready = grant_rd;
                    if (acc_decerr) nxt = grant_wr ? ST_WRESP : ST_RRESP;
                    else            nxt = ST_SETUP;
                end
            end
            ST_SETUP:  nxt = ST_ACCESS;
            ST_ACCESS: if (sel_ready || timeout) nxt = pwrite_q ? ST_WRESP : ST_RRESP;
            ST_WRESP:  if (bready) nxt = ST_IDLE;
            ST_RRESP:  if (rready) nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    // NOTE: the datapath is reset too, since paddr/pwdata/rdata must read zero after reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            resp_q   <= RESP_OKAY;
            rdata_q  <= '0;
            last_wr  <= 1'b0;
        end else begin
            if (grant_wr || grant_rd) begin
                addr_q   <= acc_addr;
                idx_q    <= acc_idx;
                pwrite_q <= grant_wr;
                last_wr  <= grant_wr;
                if (grant_wr) begin
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                end
                if (acc_decerr) begin
                    resp_q  <= RESP_DECERR;
                    rdata_q <= '0;
                end
            end
            if (cur == ST_ACCESS) begin
                if (sel_ready) begin
                    resp_q <= sel_err ? RESP_SLVERR : RESP_OKAY;
                    if (!pwrite_q) rdata_q <= sel_rdata;
                end else if (timeout) begin
                    resp_q  <= RESP_SLVERR;
                    rdata_q <= '0;
                end
            end
        end
    end

    assign penable = (cur == ST_ACCESS);
    assign pwrite  = pwrite_q;
    assign paddr   = addr_q;
    assign pwdata  = wdata_q;
    assign pstrb   = (xfer_act && pwrite_q) ? wstrb_q : '0;
    assign bvalid  = (cur == ST_WRESP);
    assign rvalid  = (cur == ST_RRESP);
    assign bresp   = (cur == ST_WRESP) ? resp_q : RESP_OKAY;
    assign rresp   = (cur == ST_RRESP) ? resp_q : RESP_OKAY;
    assign rdata   = rdata_q;
    assign state   = cur;

endmodule

// File: tb/tb_axil_apb_bridge_ms.sv
// Directed bench for axil_apb_bridge_ms: a 4-completer instance with a simple APB completer
// model, plus a 3-completer instance for decode errors. Define APB_TIMEOUT_EN to cover the timeout.
module tb_axil_apb_bridge_ms;

    logic        aclk = 1'b0;
    logic        areset;
    always #5 aclk = ~aclk;

    // main instance, NUM_SLV = 4
    logic [31:0]  awaddr, araddr, wdata;
    logic [3:0]   wstrb;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata, paddr, pwdata;
    logic [3:0]   psel, pstrb, pready, pslverr;
    logic         penable, pwrite;
    logic [127:0] prdata;
    logic [2:0]   state;

    axil_apb_bridge_ms #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SEL_LSB(12), .TIMEOUT_CYC(8)
    ) u_dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .state(state)
    );

    // second instance, NUM_SLV = 3, read-only stimulus
    logic [31:0] d3_araddr;
    logic        d3_arvalid, d3_rready;
    logic        d3_awready, d3_wready, d3_bvalid, d3_arready, d3_rvalid;
    logic [1:0]  d3_bresp, d3_rresp;
    logic [31:0] d3_rdata, d3_paddr, d3_pwdata;
    logic [2:0]  d3_psel;
    logic [3:0]  d3_pstrb;
    logic        d3_penable, d3_pwrite;
    logic [2:0]  d3_state;
    logic [95:0] d3_prdata = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

    axil_apb_bridge_ms #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SEL_LSB(12), .TIMEOUT_CYC(8)
    ) u_dut3 (
        .aclk(aclk), .areset(areset),
        .awaddr(32'h0), .awvalid(1'b0), .awready(d3_awready),
        .wdata(32'h0), .wstrb(4'h0), .wvalid(1'b0), .wready(d3_wready),
        .bresp(d3_bresp), .bvalid(d3_bvalid), .bready(1'b0),
        .araddr(d3_araddr), .arvalid(d3_arvalid), .arready(d3_arready),
        .rdata(d3_rdata), .rresp(d3_rresp), .rvalid(d3_rvalid), .rready(d3_rready),
        .psel(d3_psel), .penable(d3_penable), .pwrite(d3_pwrite), .paddr(d3_paddr),
        .pwdata(d3_pwdata), .pstrb(d3_pstrb), .prdata(d3_prdata), .pready(3'b111),
        .pslverr(3'b000), .state(d3_state)
    );

    // APB completer model: ready after wait_states ACCESS cycles unless stuck
    int          wait_states = 0;
    bit          stuck = 1'b0;
    bit          err_flag = 1'b0;
    int          rd_slv = 3;
    logic [31:0] rd_value = 32'h1234_5678;
    int          acc_cnt = 0;

    always @(posedge aclk) begin
        if (penable) acc_cnt <= acc_cnt + 1;
        else         acc_cnt <= 0;
    end

    always_comb begin
        pready  = (penable && !stuck && acc_cnt >= wait_states) ? psel : 4'b0000;
        pslverr = err_flag ? psel : 4'b0000;
        for (int i = 0; i < 4; i++)
            prdata[i*32 +: 32] = (i == rd_slv) ? rd_value : (32'hBAD0_0000 | i);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        d3_araddr = '0; d3_arvalid = 1'b0; d3_rready = 1'b0;

        // ---- reset values (valids held high to show grants are masked)
        tick(); tick();
        check("rst_state",   state,   3'd0);
        check("rst_awready", awready, 1'b0);
        check("rst_wready",  wready,  1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid",  bvalid,  1'b0);
        check("rst_rvalid",  rvalid,  1'b0);
        check("rst_psel",    psel,    4'b0000);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite",  pwrite,  1'b0);
        check("rst_pstrb",   pstrb,   4'h0);
        check("rst_paddr",   paddr,   32'h0);
        check("rst_pwdata",  pwdata,  32'h0);
        check("rst_rdata",   rdata,   32'h0);
        check("rst_bresp",   bresp,   2'b00);
        check("rst_rresp",   rresp,   2'b00);
        check("rst3_awready", d3_awready, 1'b0);
        check("rst3_wready",  d3_wready,  1'b0);
        check("rst3_bresp",   d3_bresp,   2'b00);
        check("rst3_pwrite",  d3_pwrite,  1'b0);
        check("rst3_pwdata",  d3_pwdata,  32'h0);
        check("rst3_pstrb",   d3_pstrb,   4'h0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        areset = 1'b0;
        tick();

        // ---- zero-wait write to completer 1
        awaddr = 32'h0000_1004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("wr_awready", awready, 1'b1);
        check("wr_wready",  wready,  1'b1);
        check("wr_arready", arready, 1'b0);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        check("wr_setup_state",   state,   3'd1);
        check("wr_setup_psel",    psel,    4'b0010);
        check("wr_setup_penable", penable, 1'b0);
        check("wr_setup_pwrite",  pwrite,  1'b1);
        check("wr_setup_paddr",   paddr,   32'h0000_1004);
        check("wr_setup_pwdata",  pwdata,  32'hDEAD_BEEF);
        check("wr_setup_pstrb",   pstrb,   4'hF);
        check("wr_setup_awready", awready, 1'b0);
        tick();
        check("wr_acc_state",   state,   3'd2);
        check("wr_acc_psel",    psel,    4'b0010);
        check("wr_acc_penable", penable, 1'b1);
        check("wr_acc_pstrb",   pstrb,   4'hF);
        check("wr_acc_bvalid",  bvalid,  1'b0);
        tick();
        check("wr_resp_state",  state,   3'd3);
        check("wr_resp_bvalid", bvalid,  1'b1);
        check("wr_resp_bresp",  bresp,   2'b00);
        check("wr_resp_psel",   psel,    4'b0000);
        check("wr_resp_pen",    penable, 1'b0);
        check("wr_resp_pstrb",  pstrb,   4'h0);
        check("wr_resp_paddr",  paddr,   32'h0000_1004);
        tick();
        check("wr_hold_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wr_done_state",  state,  3'd0);
        check("wr_done_bvalid", bvalid, 1'b0);

        // ---- read from completer 3 with two wait states
        wait_states = 2; rd_slv = 3; rd_value = 32'h1234_5678;
        araddr = 32'h0000_3000; arvalid = 1'b1;
        #1;
        check("rd_arready", arready, 1'b1);
        check("rd_awready", awready, 1'b0);
        tick();
        arvalid = 1'b0;
        #1;
        check("rd_setup_state", state,  3'd1);
        check("rd_setup_psel",  psel,   4'b1000);
        check("rd_setup_pwrite", pwrite, 1'b0);
        check("rd_setup_pstrb", pstrb,  4'h0);
        check("rd_setup_paddr", paddr,  32'h0000_3000);
        check("rd_setup_pwdata", pwdata, 32'hDEAD_BEEF);
        tick();
        check("rd_acc1_state", state, 3'd2);
        tick();
        check("rd_acc2_state", state, 3'd2);
        tick();
        check("rd_acc3_state", state, 3'd2);
        check("rd_acc3_psel",  psel,  4'b1000);
        tick();
        check("rd_resp_state",  state,  3'd4);
        check("rd_resp_rvalid", rvalid, 1'b1);
        check("rd_resp_rdata",  rdata,  32'h1234_5678);
        check("rd_resp_rresp",  rresp,  2'b00);
        tick();
        check("rd_hold_rvalid", rvalid, 1'b1);
        check("rd_hold_rdata",  rdata,  32'h1234_5678);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd_done_state",  state,  3'd0);
        check("rd_done_rvalid", rvalid, 1'b0);

        // ---- write to completer 0 answered with pslverr
        wait_states = 0; err_flag = 1'b1;
        awaddr = 32'h0000_0010; wdata = 32'h0BAD_F00D; wstrb = 4'h3;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        check("err_setup_psel",  psel,  4'b0001);
        check("err_setup_pstrb", pstrb, 4'h3);
        tick();
        check("err_acc_state", state, 3'd2);
        tick();
        check("err_resp_bvalid", bvalid, 1'b1);
        check("err_resp_bresp",  bresp,  2'b10);
        bready = 1'b1;
        tick();
        bready = 1'b0; err_flag = 1'b0;
        check("err_done_state", state, 3'd0);

        // ---- arbitration after a fresh reset: write, read, write
        areset = 1'b1;
        tick();
        areset = 1'b0;
        awaddr = 32'h0000_2008; araddr = 32'h0000_200C; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        rd_slv = 3; bready = 1'b1; rready = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("arb1_awready", awready, 1'b1);
        check("arb1_arready", arready, 1'b0);
        tick();
        check("arb1_pwrite", pwrite, 1'b1);
        check("arb1_psel",   psel,   4'b0100);
        tick();
        check("arb1_busy_awready", awready, 1'b0);
        check("arb1_busy_arready", arready, 1'b0);
        tick();
        check("arb1_bvalid", bvalid, 1'b1);
        tick();
        check("arb2_awready", awready, 1'b0);
        check("arb2_arready", arready, 1'b1);
        tick();
        check("arb2_pwrite", pwrite, 1'b0);
        check("arb2_paddr",  paddr,  32'h0000_200C);
        tick();
        tick();
        check("arb2_rvalid", rvalid, 1'b1);
        check("arb2_rdata",  rdata,  32'hBAD0_0002);
        tick();
        check("arb3_awready", awready, 1'b1);
        check("arb3_arready", arready, 1'b0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        tick();

`ifdef APB_TIMEOUT_EN
        // ---- completer never ready: SLVERR after 8 ACCESS cycles
        stuck = 1'b1;
        awaddr = 32'h0000_1000; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        for (int i = 1; i < 8; i++) tick();
        check("tmo_acc8_state",   state,   3'd2);
        check("tmo_acc8_penable", penable, 1'b1);
        tick();
        check("tmo_resp_state",  state,  3'd3);
        check("tmo_resp_bvalid", bvalid, 1'b1);
        check("tmo_resp_bresp",  bresp,  2'b10);
        check("tmo_resp_psel",   psel,   4'b0000);
        bready = 1'b1;
        tick();
        bready = 1'b0; stuck = 1'b0;
        check("tmo_done_state", state, 3'd0);
`endif

        // ---- reset in the middle of ACCESS abandons the write
        stuck = 1'b1;
        awaddr = 32'h0000_1020; wdata = 32'h5555_AAAA; wstrb = 4'hC;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("mid_acc_state", state, 3'd2);
        areset = 1'b1;
        tick();
        check("mid_rst_state",   state,   3'd0);
        check("mid_rst_psel",    psel,    4'b0000);
        check("mid_rst_penable", penable, 1'b0);
        check("mid_rst_pwrite",  pwrite,  1'b0);
        check("mid_rst_pstrb",   pstrb,   4'h0);
        check("mid_rst_paddr",   paddr,   32'h0);
        check("mid_rst_pwdata",  pwdata,  32'h0);
        check("mid_rst_bvalid",  bvalid,  1'b0);
        areset = 1'b0; stuck = 1'b0;
        tick();
        tick();
        check("mid_after_bvalid", bvalid, 1'b0);
        check("mid_after_state",  state,  3'd0);

        // ---- 3-completer instance: valid read, then decode error
        d3_araddr = 32'h0000_2000; d3_arvalid = 1'b1;
        #1;
        check("d3_ok_arready", d3_arready, 1'b1);
        tick();
        d3_arvalid = 1'b0;
        #1;
        check("d3_ok_psel", d3_psel, 3'b100);
        tick();
        check("d3_ok_penable", d3_penable, 1'b1);
        tick();
        check("d3_ok_rvalid", d3_rvalid, 1'b1);
        check("d3_ok_rdata",  d3_rdata,  32'hC0DE_0002);
        d3_rready = 1'b1;
        tick();
        d3_rready = 1'b0;
        d3_araddr = 32'h0000_3000; d3_arvalid = 1'b1;
        #1;
        check("d3_dec_arready", d3_arready, 1'b1);
        tick();
        d3_arvalid = 1'b0;
        #1;
        check("d3_dec_state",  d3_state,  3'd4);
        check("d3_dec_psel",   d3_psel,   3'b000);
        check("d3_dec_pen",    d3_penable, 1'b0);
        check("d3_dec_rvalid", d3_rvalid, 1'b1);
        check("d3_dec_rresp",  d3_rresp,  2'b11);
        check("d3_dec_rdata",  d3_rdata,  32'h0);
        check("d3_dec_paddr",  d3_paddr,  32'h0000_3000);
        d3_rready = 1'b1;
        tick();
        d3_rready = 1'b0;
        check("d3_dec_done",   d3_state,  3'd0);
        check("d3_bvalid",     d3_bvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_apb_bridge_ms.md
AXIL_APB_BRIDGE_MS -- requirements
Module: axil_apb_bridge_ms

Interface
REQ-001 SHALL have parameter ADDR_W, 32, AXI/APB address width.
REQ-002 SHALL have parameter DATA_W, 32, data width; legal values 8, 16, 32.
REQ-003 SHALL have parameter NUM_SLV, 4, number of APB completers (1..16).
REQ-004 SHALL have parameter SEL_LSB, 12, lowest address bit of the completer-select field.
REQ-005 SHALL have parameter TIMEOUT_CYC, 256, maximum ACCESS-phase cycles when timeout is compiled in.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports: aclk  in  1  clock; areset  in  1  synchronous active-high reset.
REQ-007 SHALL have AXI-Lite write ports: awaddr in ADDR_W; awvalid in 1; awready out 1; wdata in DATA_W; wstrb in DATA_W/8; wvalid in 1; wready out 1; bresp out 2; bvalid out 1; bready in 1.
REQ-008 SHALL have AXI-Lite read ports: araddr in ADDR_W; arvalid in 1; arready out 1; rdata out DATA_W; rresp out 2; rvalid out 1; rready in 1.
REQ-009 SHALL have APB ports: psel out NUM_SLV one-hot; penable out 1; pwrite out 1; paddr out ADDR_W; pwdata out DATA_W; pstrb out DATA_W/8; prdata in NUM_SLV*DATA_W (slave i at [i*DATA_W +: DATA_W]); pready in NUM_SLV; pslverr in NUM_SLV.
REQ-010 SHALL have debug port state out 3, the current FSM encoding.

Function
REQ-011 FSM states SHALL be IDLE(0), SETUP(1), ACCESS(2), WRESP(3), RRESP(4).
REQ-012 In IDLE, a write SHALL be accepted only when awvalid and wvalid are both high; awready and wready SHALL pulse together for exactly that cycle.
REQ-013 In IDLE, a read SHALL be accepted when arvalid is high, with a one-cycle arready pulse.
REQ-014 When write and read are both pending in IDLE, the bridge SHALL grant the type not granted last; the first grant after reset SHALL go to write.
REQ-015 On acceptance, address, wdata, wstrb and pwrite SHALL be registered; index = addr[SEL_LSB +: clog2(NUM_SLV)], with 0 bits used when NUM_SLV=1.
REQ-016 When index >= NUM_SLV, no APB transfer SHALL occur; the FSM SHALL go directly to WRESP/RRESP with resp=2'b11 (DECERR) and rdata=0.
REQ-017 SETUP SHALL last one cycle with psel[index]=1 and penable=0; ACCESS SHALL keep psel and set penable=1 until pready[index]=1.
REQ-018 pstrb SHALL equal the registered wstrb for writes and 0 for reads.
REQ-019 On the pready cycle, resp SHALL be 2'b10 if pslverr[index] is high, else 2'b00; read data SHALL be captured from prdata slice index.
REQ-020 bvalid/rvalid SHALL assert the cycle after completion, hold resp/rdata stable, and fall after the bready/rready handshake; the FSM then returns to IDLE.
REQ-021 Throughput SHALL be at most one transaction per 4 cycles (IDLE, SETUP, ACCESS, RESP) with zero-wait completers.
REQ-022 Outside SETUP/ACCESS, psel, penable and pstrb SHALL be 0; paddr/pwdata SHALL hold their last values.
REQ-023 awaddr/araddr low bits SHALL pass through unchanged; no alignment checks are made.

Reset
REQ-024 While areset is high at an aclk edge, the FSM SHALL go to IDLE and all ready/valid outputs, psel, penable, pwrite, pstrb, bresp and rresp SHALL become 0; paddr, pwdata and rdata SHALL become 0; the arbitration history SHALL clear.
REQ-025 Reset mid-transfer SHALL abandon the transfer with no response issued.

Configuration
REQ-026 With APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if it reaches TIMEOUT_CYC without pready, the transfer SHALL end with resp=2'b10, rdata=0, and psel/penable dropped.
REQ-027 Without APB_TIMEOUT_EN, no counter SHALL be built, and ACCESS SHALL wait indefinitely.

Structure
REQ-028 A package axil_apb_pkg SHALL hold the FSM state enum, response constants (OKAY, SLVERR, DECERR) and the slave-select width function.
REQ-029 A sub-module apb_slv_mux SHALL decode the index into psel and select prdata/pready/pslverr; no other sub-modules SHALL be used.

Verification
REQ-030 Write 0x0000_1004 data 0xDEADBEEF wstrb 0xF, completer 1 zero-wait -> psel=4'b0010 in SETUP then ACCESS, pstrb=0xF, bresp=00 four cycles after acceptance.
REQ-031 Read 0x0000_3000, completer 3 with 2 wait states returning 0x12345678 -> rdata=0x12345678, rresp=00, rvalid held until rready.
REQ-032 With NUM_SLV=3, read 0x0000_3000 -> no psel activity, rresp=11, rdata=0.
REQ-033 awvalid, wvalid and arvalid asserted together twice after reset -> write is served first, then read, then write.
REQ-034 Write to completer 0 with pslverr=1 on pready -> bresp=10; with APB_TIMEOUT_EN, TIMEOUT_CYC=8 and pready stuck low -> bresp=10 after 8 ACCESS cycles.
REQ-035 areset raised during ACCESS -> next cycle all outputs at reset values, state=0, and no bvalid is issued.
